// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider with 50% duty cycle for odd and even N.
// Divisor changes land only on a period boundary; tick marks each period start in the clk domain.
module clk_div_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             load_pending,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);

  logic [WIDTH-1:0] cnt, cnt_next, pending, div_next;
  logic [WIDTH:0]   half_n;
  logic             running, p, n;
  logic             start, boundary, load_ok;

  always_comb begin
    start    = enable & ~running;
    cnt_next = (cnt == div_active - ONE) ? '0 : cnt + ONE;
    boundary = start | (enable & running & (cnt_next == '0));
    // The new period's phase must be computed with the divisor it will run at.
    div_next = (boundary & load_pending) ? pending : div_active;
    half_n   = ({1'b0, div_next} + ONE_W) >> 1;
    load_ok  = div_load & (div_in > ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      running      <= 1'b0;
      p            <= 1'b0;
      tick         <= 1'b0;
      div_active   <= WIDTH'(DEFAULT_DIV);
      pending      <= '0;
      load_pending <= 1'b0;
      div_err      <= 1'b0;
    end else begin
      div_err <= div_load & ~load_ok;
      if (boundary && load_pending) begin
        div_active   <= pending;
        load_pending <= 1'b0;
      end
      // A load in the boundary cycle queues behind the one just applied.
      if (load_ok) begin
        pending      <= div_in;
        load_pending <= 1'b1;
      end
      if (!enable) begin
        cnt     <= '0;
        running <= 1'b0;
        p       <= 1'b0;
        tick    <= 1'b0;
      end else if (start) begin
        cnt     <= '0;
        running <= 1'b1;
        p       <= 1'b1;
        tick    <= 1'b1;
      end else begin
        cnt  <= cnt_next;
        tick <= (cnt_next == '0);
        p    <= ({1'b0, cnt_next} < half_n);
      end
    end
  end

  // Half-cycle delayed phase; ANDing it in trims odd-N high time by half a cycle.
  always_ff @(negedge clk) begin
    if (reset) n <= 1'b0;
    else       n <= p;
  end

  assign clk_out = div_active[0] ? (p & n) : p;

endmodule

// File: tb/tb_clk_div_n.sv
// Directed bench for clk_div_n: expected periods are queued by the stimulus and
// checked by an independent monitor measuring period length and high time in half cycles.
module tb_clk_div_n;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset, enable, div_load;
  logic [WIDTH-1:0] div_in;
  logic             clk_out, tick, load_pending, div_err;
  logic [WIDTH-1:0] div_active;

  typedef struct {
    int len;
    int hi;
    int div;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  clk_div_n #(.WIDTH(WIDTH), .DEFAULT_DIV(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .div_in(div_in), .div_load(div_load),
    .clk_out(clk_out), .tick(tick), .div_active(div_active),
    .load_pending(load_pending), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A period of divisor N lasts N cycles and is high for N half cycles.
  task automatic push(input int dv, input int k);
    repeat (k) q.push_back('{len: dv, hi: dv, div: dv});
  endtask

  // Inputs change 3 time units after a negedge; each call consumes k posedges.
  task automatic step(input int k);
    repeat (k) @(negedge clk);
    #3;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_clk_out"}, clk_out, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_div_active"}, div_active, 3);
    chk({tag, "_load_pending"}, load_pending, 0);
    chk({tag, "_div_err"}, div_err, 0);
  endtask

  // Monitor: a tick opens a period; the next tick closes and scores it.
  initial begin : mon
    int   cyc, hi, dv;
    bit   act;
    exp_t e;
    act = 0; cyc = 0; hi = 0; dv = 0;
    forever begin
      @(posedge clk); #1;
      if (reset || !enable) act = 0;
      else if (tick) begin
        if (act) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL period_unexpected: got len %0d div %0d expected none", cyc, dv);
          end else begin
            e = q.pop_front();
            chk("period_len", cyc, e.len);
            chk("period_high_halves", hi, e.hi);
            chk("period_div", dv, e.div);
          end
        end
        act = 1; cyc = 0; hi = 0; dv = int'(div_active);
      end
      if (act) begin cyc++; hi += int'(clk_out); end
      @(negedge clk); #1;
      if (act) hi += int'(clk_out);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_in = '0;
    repeat (3) begin step(1); idle_chk("reset"); end
    reset = 1'b0;
    repeat (3) begin step(1); idle_chk("idle"); end

    push(3, 4); push(4, 2); push(5, 2); push(8, 1); push(7, 3); push(5, 1); push(3, 1);

    enable = 1'b1;
    step(1);
    chk("start_tick", tick, 1);
    chk("start_div", div_active, 3);
    step(10);
    div_load = 1'b1; div_in = 8'd4;
    step(1);
    div_load = 1'b0;
    chk("load4_pending", load_pending, 1);
    chk("load4_div_old", div_active, 3);
    chk("load4_tick", tick, 0);
    step(1);
    chk("bound4_div", div_active, 4);
    chk("bound4_pending", load_pending, 0);
    chk("bound4_tick", tick, 1);

    div_load = 1'b1; div_in = 8'd1;
    step(1);
    chk("err1_div_err", div_err, 1);
    chk("err1_div", div_active, 4);
    chk("err1_pending", load_pending, 0);
    div_in = 8'd0;
    step(1);
    chk("err0_div_err", div_err, 1);
    div_load = 1'b0;
    step(1);
    chk("err_clear", div_err, 0);

    div_load = 1'b1; div_in = 8'd5;
    step(1);
    div_load = 1'b0;
    chk("load5_at_bound_tick", tick, 1);
    chk("load5_at_bound_div", div_active, 4);
    chk("load5_at_bound_pending", load_pending, 1);
    step(4);
    chk("bound5_div", div_active, 5);
    chk("bound5_pending", load_pending, 0);
    chk("bound5_tick", tick, 1);
    step(5);

    div_load = 1'b1; div_in = 8'd6;
    step(1);
    div_in = 8'd8;
    step(1);
    div_load = 1'b0;
    step(2);
    chk("load68_pending", load_pending, 1);
    chk("load68_div_old", div_active, 5);
    div_load = 1'b1; div_in = 8'd7;
    step(1);
    div_load = 1'b0;
    chk("bound8_tick", tick, 1);
    chk("bound8_div", div_active, 8);
    chk("load7_queued", load_pending, 1);
    step(8);
    chk("bound7_div", div_active, 7);
    chk("bound7_pending", load_pending, 0);
    chk("bound7_tick", tick, 1);
    step(14);

    div_load = 1'b1; div_in = 8'd5;
    step(1);
    div_load = 1'b0;
    step(6);
    chk("bound5b_div", div_active, 5);
    chk("bound5b_tick", tick, 1);
    step(5);
    chk("p64_tick", tick, 1);

    div_load = 1'b1; div_in = 8'd9;
    step(1);
    div_load = 1'b0;
    step(1);
    chk("load9_pending", load_pending, 1);
    reset = 1'b1;
    step(1);
    chk("midreset_clk_out", clk_out, 0);
    chk("midreset_tick", tick, 0);
    chk("midreset_div", div_active, 3);
    chk("midreset_pending", load_pending, 0);
    reset = 1'b0;
    step(1);
    chk("restart_tick", tick, 1);
    chk("restart_div", div_active, 3);
    chk("restart_clk_out", clk_out, 1);
    step(4);

    enable = 1'b0;
    step(1);
    chk("stop_clk_out", clk_out, 0);
    chk("stop_tick", tick, 0);
    div_load = 1'b1; div_in = 8'd4;
    step(1);
    div_load = 1'b0;
    step(1);
    chk("stopped_pending", load_pending, 1);
    chk("stopped_div", div_active, 3);
    chk("stopped_clk_out", clk_out, 0);

    push(4, 2);
    enable = 1'b1;
    step(1);
    chk("reenable_tick", tick, 1);
    chk("reenable_div", div_active, 4);
    chk("reenable_pending", load_pending, 0);
    chk("reenable_clk_out", clk_out, 1);
    step(8);
    step(2);

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
